double_dabble_converter: RTL and testbench

- Sequential binary-to-BCD converter using the shift-and-add-3 (double dabble) algorithm.
- Accepts an unsigned binary word with a valid strobe and iterates one bit per clock.
- Emits packed BCD digits with a one-cycle valid pulse.
- Sits in front of the seven-segment display driver, which registers the packed BCD on the valid pulse.

---
 rtl/double_dabble_converter.sv | 134 +++++++++++++
 tb/tb_double_dabble_converter.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/double_dabble_converter.sv
// double_dabble_converter
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble).
// A request is accepted while idle. The converter then runs one iteration per
// clock, and the packed BCD result appears with a single-cycle valid pulse
// NUM_BITS edges after the accepting edge. Values that need more than
// NUM_DIGITS digits are truncated to the value mod 10^NUM_DIGITS.
//
// Optional feature: define DOUBLE_DABBLE_OVERFLOW_EN to add an 'overflow'
// output. It flags results whose input exceeded 10^NUM_DIGITS-1.

module double_dabble_converter #(
    parameter int NUM_BITS   = 14,
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BITS-1:0]     binary_in,
    input  logic                    binary_in_valid,
    output logic [4*NUM_DIGITS-1:0] packed_bcd_out,
    output logic                    packed_bcd_out_valid,
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
    output logic                    overflow,
`endif
    output logic                    busy
);

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int CNT_W  = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int JOIN_W = BCD_W + NUM_BITS;

    // The counter holds the number of iterations already done. The edge that
    // sees LAST_ITER performs the final iteration.
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(NUM_BITS - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] CONVERT = 1'b1;

    logic [0:0]          state;
    logic [NUM_BITS-1:0] bin_shift;
    logic [BCD_W-1:0]    scratch;
    logic [CNT_W-1:0]    bit_count;

    logic [BCD_W-1:0]    adjusted;
    logic [JOIN_W-1:0]   joined_next;
    logic [BCD_W-1:0]    scratch_next;
    logic [NUM_BITS-1:0] bin_next;

`ifdef DOUBLE_DABBLE_OVERFLOW_EN
    // Largest value that fits in NUM_DIGITS decimal digits. This assumes
    // NUM_BITS <= 64, which covers any practical display width.
    function automatic logic [63:0] max_decimal();
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_DECIMAL = max_decimal();

    logic overflow_pending;
`endif

    // Add-3 step: every scratch digit of 5 or more gets +3 before the shift,
    // so that the doubling carries correctly into the next decimal digit.
    always_comb begin
        adjusted = scratch;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // Shift the joined {scratch, binary} word left by one bit. The top bit of
    // the scratch falls off, which gives the mod 10^NUM_DIGITS truncation.
    always_comb begin
        joined_next  = {adjusted, bin_shift} << 1;
        scratch_next = joined_next[JOIN_W-1:NUM_BITS];
        bin_next     = joined_next[NUM_BITS-1:0];
    end

    // Control FSM and datapath registers: accept, iterate, publish the result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            bin_shift            <= '0;
            scratch              <= '0;
            bit_count            <= '0;
            packed_bcd_out       <= '0;
            packed_bcd_out_valid <= 1'b0;
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
            overflow_pending     <= 1'b0;
            overflow             <= 1'b0;
`endif
        end else begin
            packed_bcd_out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (binary_in_valid) begin
                        bin_shift <= binary_in;
                        scratch   <= '0;
                        bit_count <= '0;
                        state     <= CONVERT;
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
                        overflow_pending <= (64'(binary_in) > MAX_DECIMAL);
`endif
                    end
                end
                CONVERT: begin
                    scratch   <= scratch_next;
                    bin_shift <= bin_next;
                    bit_count <= bit_count + 1'b1;
                    if (bit_count == LAST_ITER) begin
                        packed_bcd_out       <= scratch_next;
                        packed_bcd_out_valid <= 1'b1;
                        bit_count            <= '0;
                        state                <= IDLE;
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
                        overflow             <= overflow_pending;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state == CONVERT);

endmodule

// File: tb/tb_double_dabble_converter.sv
// tb_double_dabble_converter
// Directed-vector bench for double_dabble_converter with default parameters.
// Expected BCD values are hand-computed constants.

module tb_double_dabble_converter;

    logic        clk;
    logic        reset;
    logic [13:0] binary_in;
    logic        binary_in_valid;
    logic [15:0] packed_bcd_out;
    logic        packed_bcd_out_valid;
    logic        busy;
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
    logic        overflow;
`endif

    int vectorCount = 0;
    int missCount   = 0;

    double_dabble_converter #(
        .NUM_BITS   (14),
        .NUM_DIGITS (4)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .binary_in            (binary_in),
        .binary_in_valid      (binary_in_valid),
        .packed_bcd_out       (packed_bcd_out),
        .packed_bcd_out_valid (packed_bcd_out_valid),
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
        .overflow             (overflow),
`endif
        .busy                 (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts the comparison and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request, wait for its result, and check latency, value, pulse
    // width and busy.
    task automatic applyStimulus(input logic [13:0] value, input logic [15:0] expBcd,
                                 input string tag);
        int cycles;
        @(negedge clk);
        binary_in       = value;
        binary_in_valid = 1'b1;
        @(negedge clk);
        binary_in_valid = 1'b0;
        binary_in       = 14'h2AAA;
        checkOutput({tag, " busy after accept"}, 32'(busy), 32'd1);
        cycles = 0;
        while (!packed_bcd_out_valid && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'd14);
        checkOutput({tag, " result"}, 32'(packed_bcd_out), 32'(expBcd));
        @(negedge clk);
        checkOutput({tag, " valid one cycle"}, 32'(packed_bcd_out_valid), 32'd0);
        checkOutput({tag, " busy after done"}, 32'(busy), 32'd0);
        checkOutput({tag, " result held"}, 32'(packed_bcd_out), 32'(expBcd));
    endtask

    logic [13:0] sweepIn  [8] = '{14'd16383, 14'd10000, 14'd9999, 14'd5,
                                  14'd8191, 14'd12345, 14'd1000, 14'd99};
    logic [15:0] sweepExp [8] = '{16'h6383, 16'h0000, 16'h9999, 16'h0005,
                                  16'h8191, 16'h2345, 16'h1000, 16'h0099};

    // Main directed sequence
    initial begin
        int cycles;
        int pulses;
        int idx;
        int lastPulse;

        reset           = 1'b1;
        binary_in       = '0;
        binary_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset bcd", 32'(packed_bcd_out), 32'd0);
        checkOutput("reset valid", 32'(packed_bcd_out_valid), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;

        applyStimulus(14'd1234, 16'h1234, "v1234");
        applyStimulus(14'd0,    16'h0000, "v0");
        applyStimulus(14'd9999, 16'h9999, "v9999");
        applyStimulus(14'd7,    16'h0007, "v7");

        // A request raised while busy must be ignored.
        @(negedge clk);
        binary_in       = 14'd4321;
        binary_in_valid = 1'b1;
        @(negedge clk);
        binary_in_valid = 1'b0;
        repeat (4) @(negedge clk);
        binary_in       = 14'd5555;
        binary_in_valid = 1'b1;
        @(negedge clk);
        binary_in_valid = 1'b0;
        checkOutput("ignore bcd stable", 32'(packed_bcd_out), 32'h0007);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (packed_bcd_out_valid) begin
                pulses++;
                checkOutput("ignore result", 32'(packed_bcd_out), 32'h4321);
            end
            @(negedge clk);
        end
        checkOutput("ignore pulse count", 32'(pulses), 32'd1);
        applyStimulus(14'd5555, 16'h5555, "v5555");

        // Reset mid-conversion aborts without a pulse.
        @(negedge clk);
        binary_in       = 14'd9876;
        binary_in_valid = 1'b1;
        @(negedge clk);
        binary_in_valid = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort bcd", 32'(packed_bcd_out), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset  = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (packed_bcd_out_valid) pulses++;
        end
        checkOutput("abort no pulse", 32'(pulses), 32'd0);
        applyStimulus(14'd42, 16'h0042, "v42");

        // Overflow truncation
        applyStimulus(14'd16383, 16'h6383, "v16383");
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
        checkOutput("overflow set", 32'(overflow), 32'd1);
`endif
        applyStimulus(14'd100, 16'h0100, "v100");
`ifdef DOUBLE_DABBLE_OVERFLOW_EN
        checkOutput("overflow clear", 32'(overflow), 32'd0);
`endif

        // Back-to-back at maximum rate: valid held high, next value presented
        // as soon as a result pulse is seen.
        @(negedge clk);
        binary_in       = sweepIn[0];
        binary_in_valid = 1'b1;
        idx       = 0;
        cycles    = 0;
        lastPulse = -1;
        while (idx < 8 && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (packed_bcd_out_valid) begin
                checkOutput($sformatf("sweep[%0d] result", idx),
                            32'(packed_bcd_out), 32'(sweepExp[idx]));
                if (lastPulse >= 0) begin
                    checkOutput($sformatf("sweep[%0d] spacing", idx),
                                32'(cycles - lastPulse), 32'd15);
                end
                lastPulse = cycles;
                idx++;
                if (idx < 8) binary_in = sweepIn[idx];
                else binary_in_valid = 1'b0;
            end
        end
        binary_in_valid = 1'b0;
        checkOutput("sweep completed", 32'(idx), 32'd8);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
